// File: rtl/chirp_spi_pkg.sv
// Shared definitions for the chirp SPI monitor: device ids, frame lengths,
// VCO register indices and the frame FSM encoding.
package chirp_spi_pkg;

    localparam logic DEV_DAC = 1'b0;
    localparam logic DEV_VCO = 1'b1;

    localparam int DAC_FRAME_BITS = 24;
    localparam int VCO_FRAME_BITS = 32;

    localparam logic [2:0] VCO_R0 = 3'd0;
    localparam logic [2:0] VCO_R1 = 3'd1;
    localparam logic [2:0] VCO_R2 = 3'd2;
    localparam logic [2:0] VCO_R3 = 3'd3;
    localparam logic [2:0] VCO_R4 = 3'd4;
    localparam logic [2:0] VCO_R5 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // True when a VCO address maps onto one of the shadowed registers.
    function automatic logic is_shadow_addr(input logic [2:0] addr);
        return (addr <= VCO_R5);
    endfunction

endpackage

// File: rtl/chirp_spi_monitor_edge_sync.sv
// Input conditioning for the snooped SPI lines: multi-flop synchronizers,
// sclk rising-edge detect and per-bit sen fall/rise pulses.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] sen,
    input  logic       sclk,
    input  logic       mosi,
    output logic [1:0] sen_s,
    output logic [1:0] sen_fall_s,
    output logic [1:0] sen_rise_s,
    output logic       sclk_rise_s,
    output logic       mosi_s
);

    logic [1:0]             sen_chain_r [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] sclk_chain_r;
    logic [SYNC_STAGES-1:0] mosi_chain_r;
    logic [1:0]             sen_dly_r;
    logic                   sclk_dly_r;

    // Synchronizer chains; sen idles high so it resets high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sen_chain_r[i] <= 2'b11;
            end
            sclk_chain_r <= '0;
            mosi_chain_r <= '0;
        end else begin
            sen_chain_r[0] <= sen;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sen_chain_r[i] <= sen_chain_r[i-1];
            end
            sclk_chain_r <= {sclk_chain_r[SYNC_STAGES-2:0], sclk};
            mosi_chain_r <= {mosi_chain_r[SYNC_STAGES-2:0], mosi};
        end
    end

    // Delayed copies of the synchronized levels for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sen_dly_r  <= 2'b11;
            sclk_dly_r <= 1'b0;
        end else begin
            sen_dly_r  <= sen_chain_r[SYNC_STAGES-1];
            sclk_dly_r <= sclk_chain_r[SYNC_STAGES-1];
        end
    end

    assign sen_s       = sen_chain_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_chain_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_chain_r[SYNC_STAGES-1] & ~sclk_dly_r;
    assign sen_fall_s  = ~sen_s & sen_dly_r;
    assign sen_rise_s  = sen_s & ~sen_dly_r;

endmodule

// File: rtl/chirp_spi_monitor.sv
// Passive deserializer for the chirp DAC / VCO SPI bus. Decodes complete
// frames into strobed words, mirrors VCO registers R0-R5 and counts framing
// errors (wrong bit count or both enables low together).
module chirp_spi_monitor
    import chirp_spi_pkg::*;
#(
    parameter int DAC_BITS    = DAC_FRAME_BITS,
    parameter int VCO_BITS    = VCO_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  sen,
    input  logic        sclk,
    input  logic        mosi,
    output logic        dac_stb,
    output logic [7:0]  dac_prefix,
    output logic [15:0] dac_code,
    output logic        vco_stb,
    output logic [2:0]  vco_addr,
    output logic [31:0] vco_data,
    input  logic [2:0]  shadow_sel,
    output logic [31:0] shadow_data,
    output logic        frame_err,
    output logic [15:0] err_count
);

    localparam logic [5:0] DAC_LEN = 6'(DAC_BITS);
    localparam logic [5:0] VCO_LEN = 6'(VCO_BITS);

    logic [1:0]  sen_s;
    logic [1:0]  sen_fall_s;
    logic [1:0]  sen_rise_s;
    logic        sclk_rise_s;
    logic        mosi_s;

    state_t      state_r;
    state_t      state_next_s;
    logic        hold_r;
    logic        hold_next_s;
    logic        dev_r;
    logic [31:0] shift_r;
    logic [5:0]  bit_cnt_r;

    logic        start_s;
    logic        shift_en_s;
    logic        dac_load_s;
    logic        vco_load_s;
    logic        err_s;

    logic        dac_stb_r;
    logic [7:0]  dac_prefix_r;
    logic [15:0] dac_code_r;
    logic        vco_stb_r;
    logic [2:0]  vco_addr_r;
    logic [31:0] vco_data_r;
    logic        frame_err_r;
    logic [15:0] err_count_r;
    logic [31:0] shadow_r [6];
    logic [31:0] shadow_data_s;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock       (clock),
        .reset       (reset),
        .sen         (sen),
        .sclk        (sclk),
        .mosi        (mosi),
        .sen_s       (sen_s),
        .sen_fall_s  (sen_fall_s),
        .sen_rise_s  (sen_rise_s),
        .sclk_rise_s (sclk_rise_s),
        .mosi_s      (mosi_s)
    );

    // Frame FSM state, collision hold flag and latched active device.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            hold_r  <= 1'b0;
            dev_r   <= DEV_DAC;
        end else begin
            state_r <= state_next_s;
            hold_r  <= hold_next_s;
            if (start_s) begin
                dev_r <= (sen_s[1] == 1'b0) ? DEV_VCO : DEV_DAC;
            end
        end
    end

    // Next-state logic; hold keeps IDLE blind until both enables are high
    // again after a collision so the error is reported only once.
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_r;
        start_s      = 1'b0;
        shift_en_s   = 1'b0;
        dac_load_s   = 1'b0;
        vco_load_s   = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold_r) begin
                    hold_next_s = (sen_s != 2'b11);
                end else if (sen_s == 2'b00) begin
                    err_s       = 1'b1;
                    hold_next_s = 1'b1;
                end else if (sen_s != 2'b11) begin
                    start_s      = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sen_fall_s[~dev_r]) begin
                    err_s        = 1'b1;
                    hold_next_s  = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (sen_rise_s[dev_r]) begin
                    state_next_s = ST_CHECK;
                end else begin
                    shift_en_s = sclk_rise_s;
                end
            end
            ST_CHECK: begin
                state_next_s = ST_IDLE;
                if ((dev_r == DEV_DAC) && (bit_cnt_r == DAC_LEN)) begin
                    dac_load_s = 1'b1;
                end else if ((dev_r == DEV_VCO) && (bit_cnt_r == VCO_LEN)) begin
                    vco_load_s = 1'b1;
                end else begin
                    err_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                hold_next_s  = 1'b0;
            end
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_r   <= 32'd0;
            bit_cnt_r <= 6'd0;
        end else if (start_s) begin
            shift_r   <= 32'd0;
            bit_cnt_r <= 6'd0;
        end else if (shift_en_s) begin
            shift_r <= {shift_r[30:0], mosi_s};
            if (bit_cnt_r != 6'd63) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
            end
        end
    end

    // Decoded words, strobes and the saturating error counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dac_stb_r    <= 1'b0;
            dac_prefix_r <= 8'd0;
            dac_code_r   <= 16'd0;
            vco_stb_r    <= 1'b0;
            vco_addr_r   <= 3'd0;
            vco_data_r   <= 32'd0;
            frame_err_r  <= 1'b0;
            err_count_r  <= 16'd0;
        end else begin
            dac_stb_r   <= dac_load_s;
            vco_stb_r   <= vco_load_s;
            frame_err_r <= err_s;
            if (dac_load_s) begin
                dac_prefix_r <= shift_r[23:16];
                dac_code_r   <= shift_r[15:0];
            end
            if (vco_load_s) begin
                vco_data_r <= shift_r;
                vco_addr_r <= shift_r[2:0];
            end
            if (err_s && (err_count_r != 16'hFFFF)) begin
                err_count_r <= err_count_r + 16'd1;
            end
        end
    end

    // Shadow copies of VCO registers R0-R5; writes to R6/R7 are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                shadow_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (vco_load_s && is_shadow_addr(shift_r[2:0]) && (shift_r[2:0] == 3'(i))) begin
                    shadow_r[i] <= shift_r;
                end
            end
        end
    end

    // Combinational shadow read port.
    always_comb begin
        shadow_data_s = 32'd0;
        case (shadow_sel)
            VCO_R0:  shadow_data_s = shadow_r[0];
            VCO_R1:  shadow_data_s = shadow_r[1];
            VCO_R2:  shadow_data_s = shadow_r[2];
            VCO_R3:  shadow_data_s = shadow_r[3];
            VCO_R4:  shadow_data_s = shadow_r[4];
            VCO_R5:  shadow_data_s = shadow_r[5];
            default: shadow_data_s = 32'd0;
        endcase
    end

    assign dac_stb     = dac_stb_r;
    assign dac_prefix  = dac_prefix_r;
    assign dac_code    = dac_code_r;
    assign vco_stb     = vco_stb_r;
    assign vco_addr    = vco_addr_r;
    assign vco_data    = vco_data_r;
    assign frame_err   = frame_err_r;
    assign err_count   = err_count_r;
    assign shadow_data = shadow_data_s;

endmodule

// File: tb/tb_chirp_spi_monitor.sv
// Bench for chirp_spi_monitor: frames are driven as an SPI master would, and a
// frame-level model (expected-word queues with due cycles, shadow array,
// error tally) is checked against the DUT every cycle.
module tb_chirp_spi_monitor;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  sen = 2'b11;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic [2:0]  shadow_sel = 3'd0;
    logic        dac_stb;
    logic [7:0]  dac_prefix;
    logic [15:0] dac_code;
    logic        vco_stb;
    logic [2:0]  vco_addr;
    logic [31:0] vco_data;
    logic [31:0] shadow_data;
    logic        frame_err;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_err = 0;
    int err_seen = 0;
    int dac_seen = 0;
    int vco_seen = 0;
    bit rand_sel = 1'b1;

    logic [23:0] dac_q[$];
    int          dac_due_q[$];
    logic [31:0] vco_q[$];
    int          vco_due_q[$];
    logic [31:0] model_shadow [6];

    chirp_spi_monitor #(
        .DAC_BITS    (24),
        .VCO_BITS    (32),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sen         (sen),
        .sclk        (sclk),
        .mosi        (mosi),
        .dac_stb     (dac_stb),
        .dac_prefix  (dac_prefix),
        .dac_code    (dac_code),
        .vco_stb     (vco_stb),
        .vco_addr    (vco_addr),
        .vco_data    (vco_data),
        .shadow_sel  (shadow_sel),
        .shadow_data (shadow_data),
        .frame_err   (frame_err),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Frame-level model: valid length for the device gives a strobe LAT cycles
    // after sen rises at the pins, anything else is one framing error.
    task automatic model_frame(input int dev, input logic [31:0] word, input int nbits);
        if (dev == 0 && nbits == 24) begin
            dac_q.push_back(word[23:0]);
            dac_due_q.push_back(cyc + LAT);
        end else if (dev == 1 && nbits == 32) begin
            vco_q.push_back(word);
            vco_due_q.push_back(cyc + LAT);
        end else begin
            exp_err++;
        end
    endtask

    task automatic send_bits(input logic [31:0] word, input int nbits, input int half);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i % 32];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input int dev, input logic [31:0] word, input int nbits, input int half);
        sclk = 1'b0;
        sen[dev] = 1'b0;
        tick(half);
        send_bits(word, nbits, half);
        tick(half);
        sen[dev] = 1'b1;
        model_frame(dev, word, nbits);
    endtask

    task automatic settle();
        tick(LAT + 6);
        check("err_count", {16'd0, err_count}, exp_err);
        check("err_pulses", err_seen, exp_err);
    endtask

    task automatic read_shadow(input logic [2:0] sel, input logic [31:0] exp, input string name);
        rand_sel = 1'b0;
        shadow_sel = sel;
        tick(1);
        check(name, shadow_data, exp);
        rand_sel = 1'b1;
    endtask

    // Random shadow read select, exercising the read port every cycle.
    initial forever begin
        @(posedge clock);
        #1;
        if (rand_sel) shadow_sel = 3'($urandom_range(0, 7));
    end

    // Compare process: outputs against the model on every falling edge.
    initial forever begin
        logic [23:0] f;
        logic [31:0] w;
        int d;
        @(negedge clock);
        if (!reset) begin
            for (int i = 0; i < 6; i++) model_shadow[i] = 32'd0;
            check("reset_strobes", {29'd0, dac_stb, vco_stb, frame_err}, 32'd0);
            check("reset_dac", {8'd0, dac_prefix, dac_code}, 32'd0);
            check("reset_vco", vco_data ^ {29'd0, vco_addr}, 32'd0);
            check("reset_err_count", {16'd0, err_count}, 32'd0);
        end else begin
            if (dac_stb) begin
                dac_seen++;
                if (dac_q.size() == 0) begin
                    check("dac_unexpected", 32'd1, 32'd0);
                end else begin
                    f = dac_q.pop_front();
                    d = dac_due_q.pop_front();
                    check("dac_prefix", {24'd0, dac_prefix}, {24'd0, f[23:16]});
                    check("dac_code", {16'd0, dac_code}, {16'd0, f[15:0]});
                    check("dac_latency", cyc, d);
                end
            end else if (dac_due_q.size() > 0 && cyc > dac_due_q[0]) begin
                check("dac_missing", 32'd0, 32'd1);
                void'(dac_q.pop_front());
                void'(dac_due_q.pop_front());
            end
            if (vco_stb) begin
                vco_seen++;
                if (vco_q.size() == 0) begin
                    check("vco_unexpected", 32'd1, 32'd0);
                end else begin
                    w = vco_q.pop_front();
                    d = vco_due_q.pop_front();
                    check("vco_data", vco_data, w);
                    check("vco_addr", {29'd0, vco_addr}, {29'd0, w[2:0]});
                    check("vco_latency", cyc, d);
                    if (w[2:0] <= 3'd5) model_shadow[w[2:0]] = w;
                end
            end else if (vco_due_q.size() > 0 && cyc > vco_due_q[0]) begin
                check("vco_missing", 32'd0, 32'd1);
                void'(vco_q.pop_front());
                void'(vco_due_q.pop_front());
            end
            if (frame_err) err_seen++;
            check("shadow_read", shadow_data, (shadow_sel <= 3'd5) ? model_shadow[shadow_sel] : 32'd0);
        end
    end

    initial begin
        logic [31:0] vco_words [6];
        logic [15:0] code;
        int dev;
        int n;
        int half;
        int r;
        int v0;
        vco_words[0] = 32'h00400005;
        vco_words[1] = 32'h000FA23C;
        vco_words[2] = 32'h0001001B;
        vco_words[3] = 32'h65008A42;
        vco_words[4] = 32'h00007FF9;
        vco_words[5] = 32'h002C47A8;

        reset = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(4);

        // Single DAC frame
        send_frame(0, 32'h00181000, 24, 4);
        settle();
        check("first_prefix", {24'd0, dac_prefix}, 32'h18);
        check("first_code", {16'd0, dac_code}, 32'h1000);
        check("first_no_err", {16'd0, err_count}, 32'd0);

        // VCO register sequence R5..R0
        v0 = vco_seen;
        for (int k = 0; k < 6; k++) begin
            send_frame(1, vco_words[k], 32, 4);
            tick(8);
        end
        settle();
        check("vco_seq_count", vco_seen - v0, 32'd6);
        read_shadow(3'd4, 32'h000FA23C, "shadow_r4_lit");
        read_shadow(3'd0, 32'h002C47A8, "shadow_r0_lit");
        read_shadow(3'd6, 32'd0, "shadow_sel6_lit");

        // Short VCO frame
        v0 = vco_seen;
        send_frame(1, 32'hFFFFFFF8, 31, 4);
        settle();
        check("short_err_lit", {16'd0, err_count}, 32'd1);
        check("short_no_stb", vco_seen - v0, 32'd0);
        read_shadow(3'd0, 32'h002C47A8, "short_shadow_lit");

        // Back-to-back chirp sweep with one sclk period of sen high
        v0 = dac_seen;
        for (int k = 0; k < 16; k++) begin
            code = 16'((k + 1) * 4096);
            send_frame(0, {8'h00, 8'h18, code}, 24, 4);
            tick(8);
        end
        settle();
        check("sweep_count", dac_seen - v0, 32'd16);
        check("sweep_last_code", {16'd0, dac_code}, 32'h0000);
        check("sweep_err_lit", {16'd0, err_count}, 32'd1);

        // Collision mid-frame, then a clean frame
        sclk = 1'b0;
        sen[0] = 1'b0;
        tick(4);
        send_bits(32'h00ABCDEF, 8, 4);
        sen[1] = 1'b0;
        exp_err++;
        send_bits(32'h0000005A, 8, 4);
        sen[1] = 1'b1;
        send_bits(32'h000000A5, 8, 4);
        sen[0] = 1'b1;
        settle();
        sen = 2'b00;
        exp_err++;
        tick(12);
        sen = 2'b11;
        settle();
        send_frame(1, 32'h12345677, 32, 4);
        settle();
        check("collision_err_lit", {16'd0, err_count}, 32'd3);

        // Randomized frames, lengths and sclk noise while sen is high
        for (int k = 0; k < 24; k++) begin
            dev  = $urandom_range(0, 1);
            r    = $urandom_range(0, 5);
            half = $urandom_range(4, 6);
            if (r <= 3) n = (dev == 1) ? 32 : 24;
            else if (r == 4) n = (dev == 1) ? 24 : 32;
            else n = $urandom_range(1, 40);
            send_frame(dev, $urandom, n, half);
            if ($urandom_range(0, 3) == 0) begin
                repeat (2) begin
                    mosi = 1'($urandom);
                    tick(4);
                    sclk = 1'b1;
                    tick(4);
                    sclk = 1'b0;
                end
            end
            tick(2 * half);
        end
        settle();

        // Reset in the middle of a DAC frame
        sclk = 1'b0;
        sen[0] = 1'b0;
        tick(4);
        send_bits(32'h00FFFFFF, 10, 4);
        reset = 1'b0;
        exp_err = 0;
        err_seen = 0;
        tick(3);
        sen = 2'b11;
        sclk = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(6);
        v0 = dac_seen;
        send_frame(0, 32'h00185A5A, 24, 4);
        settle();
        check("reset_one_stb", dac_seen - v0, 32'd1);
        check("reset_code_lit", {16'd0, dac_code}, 32'h5A5A);
        check("reset_err_lit", {16'd0, err_count}, 32'd0);
        read_shadow(3'd4, 32'd0, "reset_shadow_lit");

        check("pending_dac", dac_q.size(), 32'd0);
        check("pending_vco", vco_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
